// File: rtl/sa_ctrl_if.sv
// Port bundle for the systolic-array sequencer: command, weight/activation
// streams, array drive and result handshake.
interface sa_ctrl_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DW    = 8,
  parameter int LEN_W = 8
);
  logic                      start;
  logic [LEN_W-1:0]          len;
  logic                      busy;
  logic                      done;
  logic                      err_len0;
  logic                      w_valid;
  logic [ROWS*DW-1:0]        w_data;
  logic                      w_ready;
  logic                      a_valid;
  logic [ROWS*DW-1:0]        a_data;
  logic                      a_ready;
  logic                      sa_fire;
  logic [ROWS*DW-1:0]        sa_data;
  logic [ROWS*DW-1:0]        sa_weight;
  logic [ROWS*COLS*32-1:0]   sa_result;
  logic                      res_valid;
  logic [ROWS*COLS*32-1:0]   res_data;
  logic                      res_ready;

  modport slave (
    input  start, len, w_valid, w_data, a_valid, a_data, sa_result, res_ready,
    output busy, done, err_len0, w_ready, a_ready, sa_fire, sa_data, sa_weight,
           res_valid, res_data
  );

  modport master (
    output start, len, w_valid, w_data, a_valid, a_data, sa_result, res_ready,
    input  busy, done, err_len0, w_ready, a_ready, sa_fire, sa_data, sa_weight,
           res_valid, res_data
  );
endinterface

// File: rtl/sa_ctrl.sv
// Tile sequencer for the systolic array: loads weights, streams skewed
// activations, drains the pipeline and hands off the captured result.
//
//   state     | meaning
//   S_IDLE    | waiting for start with nonzero len
//   S_LOAD_W  | accepting COLS weight beats
//   S_STREAM  | accepting len activation beats, firing the array
//   S_DRAIN   | DRAIN cycles for the skewed tail to flush through
//   S_CAPTURE | latch the array result
//   S_OUT     | hold result until downstream accepts
module sa_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DW    = 8,
  parameter int LEN_W = 8,
  parameter int DRAIN = ROWS + COLS - 1
) (
  input  logic       clk,
  input  logic       rst_n,
  sa_ctrl_if.slave   bus
);
  localparam int WC_W = $clog2(COLS + 1);
  localparam int DC_W = $clog2(DRAIN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_CAPTURE, S_OUT
  } state_t;

  state_t                  state_q, state_d;
  logic [WC_W-1:0]         wcnt;
  logic [LEN_W-1:0]        acnt;
  logic [LEN_W-1:0]        len_q;
  logic [DC_W-1:0]         dcnt;
  logic                    w_ready_c, a_ready_c, res_valid_c, busy_c;
  logic                    w_acc, a_acc;
  logic                    sa_fire_q, done_q, err_q;
  logic [ROWS*DW-1:0]      sa_weight_q, sa_data_q;
  logic [ROWS*COLS*32-1:0] res_data_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    w_ready_c   = 1'b0;
    a_ready_c   = 1'b0;
    res_valid_c = 1'b0;
    busy_c      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy_c = 1'b0;
        if (bus.start && bus.len != '0) state_d = S_LOAD_W;
      end
      S_LOAD_W: begin
        w_ready_c = 1'b1;
        if (bus.w_valid && wcnt == WC_W'(COLS - 1)) state_d = S_STREAM;
      end
      S_STREAM: begin
        a_ready_c = 1'b1;
        if (bus.a_valid && acnt == len_q - LEN_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (dcnt == '0) state_d = S_CAPTURE;
      end
      S_CAPTURE: state_d = S_OUT;
      S_OUT: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign w_acc = bus.w_valid && w_ready_c;
  assign a_acc = bus.a_valid && a_ready_c;

  // Drain timer reloads whenever outside DRAIN, so it always starts full.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wcnt        <= '0;
      acnt        <= '0;
      len_q       <= '0;
      dcnt        <= '0;
      sa_fire_q   <= 1'b0;
      sa_weight_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      res_data_q  <= '0;
    end else begin
      sa_fire_q   <= a_acc;
      sa_weight_q <= w_acc ? bus.w_data : '0;
      done_q      <= (state_q == S_OUT) && bus.res_ready;
      err_q       <= (state_q == S_IDLE) && bus.start && (bus.len == '0);
      if (state_q == S_IDLE && bus.start) len_q <= bus.len;
      if (state_q == S_IDLE)  wcnt <= '0;
      else if (w_acc)         wcnt <= wcnt + WC_W'(1);
      if (state_q == S_IDLE)  acnt <= '0;
      else if (a_acc)         acnt <= acnt + LEN_W'(1);
      if (state_q != S_DRAIN) dcnt <= DC_W'(DRAIN - 1);
      else                    dcnt <= dcnt - DC_W'(1);
      if (state_q == S_CAPTURE) res_data_q <= bus.sa_result;
    end
  end

  // Lane r sits behind r extra register stages so it lands r cycles after lane0.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DW-1:0] dly [0:r];
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        for (int k = 0; k <= r; k++) dly[k] <= '0;
      end else begin
        dly[0] <= a_acc ? bus.a_data[DW*r +: DW] : '0;
        for (int k = 1; k <= r; k++) dly[k] <= dly[k-1];
      end
    end
    assign sa_data_q[DW*r +: DW] = dly[r];
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_q;
  assign bus.err_len0  = err_q;
  assign bus.w_ready   = w_ready_c;
  assign bus.a_ready   = a_ready_c;
  assign bus.sa_fire   = sa_fire_q;
  assign bus.sa_data   = sa_data_q;
  assign bus.sa_weight = sa_weight_q;
  assign bus.res_valid = res_valid_c;
  assign bus.res_data  = res_data_q;
endmodule

// File: tb/tb_sa_ctrl.sv
// Directed bench for sa_ctrl: per-cycle activity is recorded as bitmasks
// indexed by cycle-since-start and compared with hand-derived values.
module tb_sa_ctrl;
  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   bad;

  logic [63:0]  fire_v, wnz_v, l0_v, l3_v, rv_v, done_v, err_v, busy_v, ar_v;
  logic [31:0]  data_a [64];
  logic [511:0] res_snap;

  localparam logic [511:0] R1 = {16{32'hCAFE_0001}};
  localparam logic [511:0] R2 = {16{32'h1234_5678}};

  sa_ctrl_if bus ();

  sa_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 64) begin
      fire_v[cyc] = bus.sa_fire;
      wnz_v[cyc]  = |bus.sa_weight;
      l0_v[cyc]   = bus.sa_data[7:0] != 8'h00;
      l3_v[cyc]   = bus.sa_data[31:24] != 8'h00;
      rv_v[cyc]   = bus.res_valid;
      done_v[cyc] = bus.done;
      err_v[cyc]  = bus.err_len0;
      busy_v[cyc] = bus.busy;
      ar_v[cyc]   = bus.a_ready;
      data_a[cyc] = bus.sa_data;
    end
  endtask

  task automatic new_tile();
    cyc    = 0;
    fire_v = '0; wnz_v = '0; l0_v = '0; l3_v = '0; rv_v = '0;
    done_v = '0; err_v = '0; busy_v = '0; ar_v = '0;
    for (int i = 0; i < 64; i++) data_a[i] = '0;
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.w_valid   = 1'b0;
    bus.w_data    = '0;
    bus.a_valid   = 1'b0;
    bus.a_data    = '0;
    bus.sa_result = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    chk("reset_ctl", 64'({bus.busy, bus.done, bus.err_len0, bus.w_ready, bus.a_ready,
                          bus.sa_fire, bus.res_valid}), 64'h0);
    chk("reset_bus", {bus.sa_data, bus.sa_weight}, 64'h0);
    chk_res("reset_res", bus.res_data, '0);
    rst_n = 1'b0;
    tick();

    // Reset in the middle of STREAM after two activations
    new_tile();
    bus.start = 1'b1; bus.len = 8'd4;
    bus.w_valid = 1'b1; bus.w_data = 32'h0101_0101;
    bus.a_valid = 1'b1; bus.a_data = 32'h0403_0201;
    bus.res_ready = 1'b1; bus.sa_result = R1;
    for (int i = 0; i < 7; i++) begin
      tick();
      bus.start = 1'b0;
    end
    chk("pre_rst_stream", 64'(bus.a_ready), 64'h1);
    rst_n = 1'b1;
    #1;
    chk("midrst_ctl", 64'({bus.busy, bus.done, bus.err_len0, bus.w_ready, bus.a_ready,
                           bus.sa_fire, bus.res_valid}), 64'h0);
    chk("midrst_bus", {bus.sa_data, bus.sa_weight}, 64'h0);
    tick();
    rst_n = 1'b0;
    new_tile();
    for (int i = 0; i < 20; i++) tick();
    chk("post_rst_rv", rv_v, 64'h0);
    chk("post_rst_busy", busy_v, 64'h0);

    // Start with len==0 is rejected
    new_tile();
    bus.start = 1'b1; bus.len = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.start = 1'b0;
    end
    chk("len0_err", err_v, 64'h2);
    chk("len0_busy", busy_v, 64'h0);

    // Basic tile, no bubbles, res_ready always high
    new_tile();
    bus.start = 1'b1; bus.len = 8'd4;
    bus.w_valid = 1'b1; bus.w_data = 32'h0101_0101;
    bus.a_valid = 1'b1; bus.a_data = 32'h0403_0201;
    bus.res_ready = 1'b1; bus.sa_result = R1;
    for (int i = 0; i < 22; i++) begin
      tick();
      bus.start = 1'b0;
      if (cyc == 17) res_snap = bus.res_data;
    end
    chk("basic_wbeats", wnz_v, 64'h3C);
    chk("basic_fire", fire_v, 64'h3C0);
    chk("basic_lane0_c6", 64'(data_a[6]), 64'h0000_0001);
    chk("basic_skew_c9", 64'(data_a[9]), 64'h0403_0201);
    chk("basic_lane3_c12", 64'(data_a[12]), 64'h0400_0000);
    chk("basic_tail_c13", 64'(data_a[13]), 64'h0);
    chk("basic_rv", rv_v, 64'h2_0000);
    chk("basic_done", done_v, 64'h4_0000);
    chk("basic_busy", busy_v, 64'h3_FFFE);
    chk_res("basic_res", res_snap, R1);

    // Activation bubbles: a_valid 1,0,0,1,1 during STREAM, len=3
    new_tile();
    bus.start = 1'b1; bus.len = 8'd3;
    bus.a_valid = 1'b1;
    begin
      logic [4:0] pat;
      pat = 5'b11001;
      for (int i = 0; i < 22; i++) begin
        tick();
        bus.start = 1'b0;
        bus.a_valid = (cyc >= 5 && cyc <= 9) ? pat[cyc-5] : 1'b1;
      end
    end
    chk("bub_fire", fire_v, 64'h640);
    chk("bub_lane0", l0_v, 64'h640);
    chk("bub_lane3", l3_v, 64'h3200);
    chk("bub_stream", ar_v, 64'h3E0);
    chk("bub_rv", rv_v, 64'h4_0000);

    // Weight stall, ignored starts, and result backpressure, len=2
    new_tile();
    bus.start = 1'b1; bus.len = 8'd2;
    bus.w_valid = 1'b0; bus.a_valid = 1'b1;
    bus.res_ready = 1'b0; bus.sa_result = R2;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      bus.start   = (cyc == 8) || (cyc == 12);
      bus.len     = (cyc == 12) ? 8'd5 : 8'd0;
      bus.w_valid = (cyc >= 1 && cyc <= 7) ? cyc[0] : 1'b1;
      bus.w_data  = {4{8'(cyc)}};
      bus.res_ready = (cyc >= 28);
      if (cyc >= 18) bus.sa_result = {16{32'hDEAD_0000 | 32'(cyc)}};
      if (cyc >= 18 && cyc <= 28 && bus.res_data !== R2) bad++;
      if (cyc == 28) res_snap = bus.res_data;
    end
    chk("stall_wbeats", wnz_v, 64'h154);
    chk("stall_stream", ar_v, 64'h300);
    chk("stall_fire", fire_v, 64'h600);
    chk("ign_start_err", err_v, 64'h0);
    chk("bp_rv", rv_v, 64'h1FFC_0000);
    chk("bp_done", done_v, 64'h2000_0000);
    chk("bp_hold", 64'(bad), 64'h0);
    chk_res("bp_res", res_snap, R2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sa_ctrl.md
Name: sa_ctrl

Overview:
- Sequencer for the 4x4 systolic array (`SA`) that turns one start command into one complete tile pass.
- Accepts weight and activation streams over valid/ready handshakes and drives the array's fire, data and weight inputs.
- Skews the activation byte lanes, drains the pipeline, captures the 512-bit result and hands it downstream over a valid/ready handshake.

Parameters:
- ROWS, 4, PE rows; one 8-bit activation lane per row.
- COLS, 4, PE columns; number of weight beats per tile.
- DW, 8, lane width; data/weight buses are ROWS*DW bits.
- LEN_W, 8, width of the activation-length field.
- DRAIN, ROWS+COLS-1, idle cycles after the last activation before the result is captured.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-high reset; asserted = 1 (name kept per codebase).
- start  in  1  one-cycle pulse; sampled only in IDLE.
- len  in  LEN_W  number of activation beats for the tile; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the result handshake completes.
- err_len0  out  1  one-cycle pulse when start arrives with len==0.
- w_valid  in  1  weight beat valid.
- w_data  in  ROWS*DW  weight beat.
- w_ready  out  1  weight beat accepted when w_valid && w_ready.
- a_valid  in  1  activation beat valid.
- a_data  in  ROWS*DW  activation beat, lane r = bits [DW*r+DW-1 : DW*r].
- a_ready  out  1  activation beat accepted when a_valid && a_ready.
- sa_fire  out  1  to SA_fire_in.
- sa_data  out  ROWS*DW  to SA_data_in (skewed).
- sa_weight  out  ROWS*DW  to SA_weight_in.
- sa_result  in  ROWS*COLS*32  from SA_result.
- res_valid  out  1  captured result valid.
- res_data  out  ROWS*COLS*32  captured result.
- res_ready  in  1  downstream accepts the result when res_valid && res_ready.

Behaviour:
- Reset (async, any state): state=IDLE, every counter=0, skew registers=0.
- Reset values of outputs: busy=0, done=0, err_len0=0, w_ready=0, a_ready=0, sa_fire=0, sa_data=0, sa_weight=0, res_valid=0, res_data=0.
- Reset mid-operation abandons the tile. No partial result is emitted.
- All sa_* outputs are registered: an accepted beat appears on them the cycle after acceptance.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, CAPTURE, OUT.
- IDLE:
  - w_ready=0, a_ready=0.
  - start && len!=0: latch len, go to LOAD_W.
  - start && len==0: pulse err_len0, stay in IDLE.
- LOAD_W:
  - w_ready=1.
  - Each accepted beat: sa_weight=w_data for exactly one cycle; wcnt increments.
  - Cycles with no accepted beat: sa_weight=0.
  - sa_fire=0 throughout.
  - After the COLS-th accepted beat (wcnt==COLS-1 && accept): go to STREAM.
- STREAM:
  - a_ready=1; acnt counts accepted beats.
  - Accepted beat: lane0 is presented the next cycle with sa_fire=1.
  - Lane r (r≥1) passes through an r-stage delay line and lands r cycles after lane0.
  - No beat (bubble): sa_fire=0 and a zero is shifted into every lane's delay line. Bubbles are legal and only stretch the timeline.
  - After the len-th accepted beat: go to DRAIN.
- DRAIN:
  - a_ready=0, sa_fire=0; zeros are shifted into the delay lines.
  - Counts exactly DRAIN cycles, measured from the cycle after the last lane0 fire.
  - The skewed tail lanes finish emerging during this window.
- CAPTURE:
  - One cycle: res_data <= sa_result, then go to OUT.
- OUT:
  - res_valid=1; res_data is held stable while res_ready=0.
  - On res_valid && res_ready: res_valid=0, done=1 for one cycle, go to IDLE.
- start outside IDLE is ignored (no queuing). busy stays 1.
- w_valid during STREAM/DRAIN/OUT is not accepted (w_ready=0).
- a_valid during LOAD_W is not accepted (a_ready=0).
- len is sampled once and stays constant for the tile. len=2^LEN_W-1 is the maximum; acnt is LEN_W wide with no wrap.
- Minimum tile latency, start to res_valid, with no bubbles and res_ready=1: 1 + COLS + len + DRAIN + 1 cycles.
  - Default parameters, len=4: 1+4+4+7+1 = 17 cycles.

Test Plan:
- Reset mid-STREAM:
  - Stimulus: start, len=4; load 4 weights; accept 2 activations; assert rst_n=1 for 1 cycle.
  - Response: all outputs 0 immediately, state IDLE, no res_valid; a new start runs a normal tile.
- Basic tile:
  - Stimulus: len=4, w/a always valid, res_ready=1; weights 0x01010101 x4; activations 0x04030201 x4.
  - Response: sa_weight nonzero for exactly 4 cycles; sa_fire high 4 consecutive cycles; lane3 byte 0x04 appears 3 cycles after its lane0 byte 0x01; res_valid at cycle 17; done pulses once.
- Bubbles:
  - Stimulus: len=3; a_valid pattern 1,0,0,1,1.
  - Response: sa_fire pattern 1,0,0,1,1; DRAIN starts after the 5th cycle; sa_data zero in all bubble lanes.
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles in OUT, with sa_result changing meanwhile.
  - Response: res_data unchanged, res_valid stays 1, done only after res_ready rises.
- Illegal and ignored commands:
  - Stimulus: start with len=0.
  - Response: err_len0 pulse, busy stays 0.
  - Stimulus: start pulsed during STREAM.
  - Response: ignored, exactly one done for the tile.
- Weight stall:
  - Stimulus: w_valid toggles 1,0,1,0,1,0,1.
  - Response: exactly 4 sa_weight beats, STREAM entered after the 4th accept, sa_fire never 1 during LOAD_W.
